// File: rtl/elevator_pkg.sv
// Shared elevator constants, common to call_panel and elevator_controller.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS      = 4;
  localparam int unsigned FLOOR_W         = 2;  // clog2(NUM_FLOORS)
  localparam int unsigned DEBOUNCE_CYCLES = 4;  // stable cycles before a debounced level moves
  localparam int unsigned CNT_W           = 3;  // 2**CNT_W > DEBOUNCE_CYCLES

endpackage

// File: rtl/call_panel_if.sv
// Call-panel bus: raw buttons and controller status in, requests and lamps out.
// master = the side that owns the buttons and the controller (bench / system).
// slave  = the call_panel itself.
interface call_panel_if import elevator_pkg::*; #(
  parameter int unsigned NumFloors = NUM_FLOORS,
  parameter int unsigned FloorW    = FLOOR_W
);

  logic [NumFloors-1:0] btn;
  logic [FloorW-1:0]    floor;
  logic                 door;
  logic [NumFloors-1:0] req;
  logic [NumFloors-1:0] lamp;

  modport master (
    output btn,
    output floor,
    output door,
    input  req,
    input  lamp
  );

  modport slave (
    input  btn,
    input  floor,
    input  door,
    output req,
    output lamp
  );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and debounced level.
// rise_o is combinational from local flops and marks the cycle in which the
// debounced level is about to go 0->1. rst_ni is sampled synchronously.
module btn_debounce import elevator_pkg::*; #(
  parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES,
  parameter int unsigned CntW           = CNT_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next state: count consecutive disagreeing cycles, adopt s2 at terminal count.
  always_comb begin
    s1_d  = btn_i;
    s2_d  = s1_q;
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      deb_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Rise strobe: terminal count reached while the synchronised level is high.
  always_comb begin
    rise_o = (s2_q != deb_q) && (cnt_q == CntLast) && s2_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/call_panel.sv
// Floor call panel: conditions raw buttons, latches accepted calls as lamps and
// signals new calls to the elevator controller on req.
// Build option CALL_PANEL_REQ_LEVEL_EN: req mirrors lamp (level) instead of a
// one-cycle pulse per accepted call.
module call_panel import elevator_pkg::*; #(
  parameter int unsigned NumFloors      = NUM_FLOORS,
  parameter int unsigned FloorW         = FLOOR_W,
  parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES,
  parameter int unsigned CntW           = CNT_W
) (
  input logic         clk,
  input logic         reset,  // synchronous, active low
  call_panel_if.slave bus
);

  logic [NumFloors-1:0] rise;
  logic [NumFloors-1:0] clear;
  logic [NumFloors-1:0] accept;
  logic [NumFloors-1:0] lamp_q, lamp_d;
  logic [NumFloors-1:0] req_q, req_d;

  for (genvar g = 0; g < NumFloors; g++) begin : g_btn
    btn_debounce #(
      .DebounceCycles (DebounceCycles),
      .CntW           (CntW)
    ) u_btn_debounce (
      .clk_i  (clk),
      .rst_ni (reset),
      .btn_i  (bus.btn[g]),
      .rise_o (rise[g])
    );
  end

  // Accept/clear: a served floor (door open there) beats a new call on it.
  always_comb begin
    clear = '0;
    for (int unsigned i = 0; i < NumFloors; i++) begin
      clear[i] = bus.door && (bus.floor == FloorW'(i));
    end
    accept = rise & ~lamp_q & ~clear;
    lamp_d = (lamp_q | accept) & ~clear;
`ifdef CALL_PANEL_REQ_LEVEL_EN
    req_d  = lamp_d;
`else
    req_d  = accept;
`endif
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lamp_q <= '0;
      req_q  <= '0;
    end else begin
      lamp_q <= lamp_d;
      req_q  <= req_d;
    end
  end

  assign bus.req  = req_q;
  assign bus.lamp = lamp_q;

endmodule

// File: tb/tb_call_panel.sv
// Bench for call_panel: directed reset/latency/serve/glitch scenarios followed
// by random button, door and reset activity, all checked against a model.
module tb_call_panel;
  import elevator_pkg::*;

  localparam int unsigned NF = NUM_FLOORS;
  localparam int unsigned D  = DEBOUNCE_CYCLES;
`ifdef CALL_PANEL_REQ_LEVEL_EN
  localparam bit LevelMode = 1'b1;
`else
  localparam bit LevelMode = 1'b0;
`endif

  logic clk;
  logic reset;

  call_panel_if #(.NumFloors(NF), .FloorW(FLOOR_W)) bus ();

  call_panel #(
    .NumFloors      (NF),
    .FloorW         (FLOOR_W),
    .DebounceCycles (D),
    .CntW           (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [NF-1:0] got, input logic [NF-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b, expected %b", tag, $time, got, exp);
    end
  endtask

  // Model: synchroniser as two delayed copies, debounce as "the last D
  // synchronised samples all disagree with the debounced level".
  logic [NF-1:0] m_s1, m_s2, m_deb, m_lamp, m_req;
  logic [NF-1:0] s2_log[$];

  task automatic model_step();
    logic [NF-1:0] rise, acc, clr;
    bit all_diff;
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_lamp = '0; m_req = '0;
      s2_log.delete();
      return;
    end
    s2_log.push_back(m_s2);
    if (s2_log.size() > D) void'(s2_log.pop_front());
    rise = '0;
    for (int i = 0; i < NF; i++) begin
      all_diff = (s2_log.size() >= D);
      for (int j = 0; j < s2_log.size(); j++) begin
        if (s2_log[j][i] == m_deb[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
        if (!m_deb[i]) rise[i] = 1'b1;
        m_deb[i] = ~m_deb[i];
      end
    end
    clr    = bus.door ? (NF'(1) << bus.floor) : '0;
    acc    = rise & ~m_lamp & ~clr;
    m_lamp = (m_lamp | acc) & ~clr;
    m_req  = LevelMode ? m_lamp : acc;
    m_s2   = m_s1;
    m_s1   = bus.btn;
  endtask

  // One clock: sample after the edge, advance the model, compare.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("req_model", bus.req, m_req);
    check("lamp_model", bus.lamp, m_lamp);
  endtask

  int hold[NF];

  initial begin
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_lamp = '0; m_req = '0;
    reset    = 1'b0;
    bus.btn  = '1;
    bus.door = 1'b0;
    bus.floor = '0;

    // Reset with all buttons held.
    repeat (2) tick();
    check("reset_req", bus.req, '0);
    check("reset_lamp", bus.lamp, '0);

    // Held buttons after reset release are fresh calls, D+2 edges later.
    reset = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("latency_early_req", bus.req, '0);
    end
    tick();
    check("latency_req", bus.req, 4'b1111);
    check("latency_lamp", bus.lamp, 4'b1111);
    tick();
    check("after_pulse_req", bus.req, LevelMode ? 4'b1111 : 4'b0000);

    // Serve floor 2.
    bus.btn   = '0;
    bus.door  = 1'b1;
    bus.floor = 2'd2;
    tick();
    check("serve_lamp", bus.lamp, 4'b1011);
    for (int f = 0; f < NF; f++) begin
      bus.floor = FLOOR_W'(f);
      tick();
    end
    check("all_clear_lamp", bus.lamp, 4'b0000);
    bus.door = 1'b0;
    repeat (8) tick();

    // Single call on floor 2.
    bus.btn = 4'b0100;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("single_early_req", bus.req, '0);
    end
    tick();
    check("single_req", bus.req, 4'b0100);
    repeat (4) begin
      tick();
      check("single_held_req", bus.req, LevelMode ? 4'b0100 : 4'b0000);
    end
    bus.btn = '0;
    repeat (8) tick();
    check("single_lamp", bus.lamp, 4'b0100);

    // Glitch on floor 1 shorter than the debounce window.
    bus.btn = 4'b0010;
    repeat (3) tick();
    bus.btn = '0;
    repeat (8) tick();
    check("glitch_lamp", bus.lamp, 4'b0100);

    // Random activity: varied hold lengths, door openings and rare resets.
    for (int i = 0; i < NF; i++) hold[i] = $urandom_range(1, 12);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NF; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          bus.btn[i] = ~bus.btn[i];
          hold[i] = $urandom_range(1, 12);
        end
      end
      bus.door  = ($urandom_range(0, 3) == 0);
      bus.floor = FLOOR_W'($urandom_range(0, NF - 1));
      reset     = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
